nand_way_sched: RTL

- Channel-level scheduler that shares one NAND channel bus (DQ, CLE, ALE, WRN, per-way CEN) among NWAY die/ways.
- Each way has its own request port.
- Grants the bus round-robin, issues the command/address/command sequence for the granted way, then releases the bus while that die is busy.
- Tracks each way's R/B line and reports completion, so ops on different ways interleave.

---
 rtl/nand_way_sched.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nand_way_sched.sv
// Round-robin scheduler sharing one NAND channel bus among NWAY ways: issues
// cmd0/address/cmd1 for the granted way, releases the bus, and reports per-way R/B completion.
module nand_way_sched #(
   parameter int NWAY     = 8,
   parameter int ADDR_CYC = 5,
   parameter int TWB      = 4
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic [NWAY-1:0]            req_valid,
   input  logic [8*NWAY-1:0]          req_cmd0,
   input  logic [8*NWAY-1:0]          req_cmd1,
   input  logic [NWAY-1:0]            req_has_cmd1,
   input  logic [8*ADDR_CYC*NWAY-1:0] req_addr,
   output logic [NWAY-1:0]            req_ready,
   output logic                       done_valid,
   output logic [$clog2(NWAY)-1:0]    done_way,
   output logic [NWAY-1:0]            CEN,
   output logic                       CLE,
   output logic                       ALE,
   output logic                       WRN,
   output logic                       WPN,
   output logic [7:0]                 DQ_O,
   output logic                       DQ_OE,
   input  logic [NWAY-1:0]            RB
);

   localparam int WW = $clog2(NWAY);
   localparam int AW = 8 * ADDR_CYC;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD0_L = 3'd1;
   localparam logic [2:0] S_CMD0_H = 3'd2;
   localparam logic [2:0] S_ADDR_L = 3'd3;
   localparam logic [2:0] S_ADDR_H = 3'd4;
   localparam logic [2:0] S_CMD1_L = 3'd5;
   localparam logic [2:0] S_CMD1_H = 3'd6;
   localparam logic [2:0] S_REL    = 3'd7;

   logic [2:0]      r_state;
   logic [WW-1:0]   r_way;
   logic [WW-1:0]   r_ptr;
   logic [7:0]      r_cmd0;
   logic [7:0]      r_cmd1;
   logic            r_has1;
   logic [AW-1:0]   r_addr;
   logic [2:0]      r_bcnt;

   logic [NWAY-1:0] r_ready;
   logic [NWAY-1:0] r_cen;
   logic            r_cle;
   logic            r_ale;
   logic            r_wrn;
   logic            r_wpn;
   logic [7:0]      r_dq;
   logic            r_dqoe;

   logic [NWAY-1:0] r_rb_m;
   logic [NWAY-1:0] r_rb_s;
   logic [NWAY-1:0] r_busy;
   logic [NWAY-1:0] r_pend;
   logic [3:0]      r_wb [NWAY];
   logic            r_done_v;
   logic [WW-1:0]   r_done_way;

   logic [NWAY-1:0] w_elig;
   logic            w_gnt_any;
   logic [WW-1:0]   w_gnt_idx;
   logic [NWAY-1:0] w_gnt_oh;
   logic [WW-1:0]   w_ptr_nxt;
   logic            w_done_any;
   logic [WW-1:0]   w_done_idx;
   logic            w_last_addr;
   logic            w_to_rel;
   logic [AW-1:0]   w_addr_shift;

   assign w_elig       = req_valid & ~r_busy;
   assign w_ptr_nxt    = (w_gnt_idx == WW'(NWAY-1)) ? '0 : w_gnt_idx + 1'b1;
   assign w_last_addr  = (r_bcnt == 3'(ADDR_CYC-1));
   assign w_addr_shift = r_addr >> 8;
   // Bus is handed back on the edge entering REL; busy is armed on that same edge.
   assign w_to_rel     = (r_state == S_CMD1_H) ||
                         ((r_state == S_ADDR_H) && w_last_addr && !r_has1);

   always_comb begin : p_grant
      int k;
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_gnt_oh  = '0;
      k         = 0;
      for (int i = 0; i < NWAY; i++) begin
         k = (int'(r_ptr) + i) % NWAY;
         if (!w_gnt_any && w_elig[k]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = WW'(k);
         end
      end
      w_gnt_oh[w_gnt_idx] = w_gnt_any;
   end

   always_comb begin
      w_done_any = |r_pend;
      w_done_idx = '0;
      for (int i = NWAY-1; i >= 0; i--) begin
         if (r_pend[i]) w_done_idx = WW'(i);
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_rb_m <= '0;
         r_rb_s <= '0;
      end else begin
         r_rb_m <= RB;
         r_rb_s <= r_rb_m;
      end
   end

   // Bus FSM; pad registers are loaded with the values of the state being entered.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= S_IDLE;
         r_way   <= '0;
         r_ptr   <= '0;
         r_cmd0  <= '0;
         r_cmd1  <= '0;
         r_has1  <= 1'b0;
         r_addr  <= '0;
         r_bcnt  <= '0;
         r_ready <= '0;
         r_cen   <= '1;
         r_cle   <= 1'b0;
         r_ale   <= 1'b0;
         r_wrn   <= 1'b1;
         r_wpn   <= 1'b0;
         r_dq    <= '0;
         r_dqoe  <= 1'b0;
      end else begin
         r_ready <= '0;
         r_wpn   <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_any) begin
                  r_ready <= w_gnt_oh;
                  r_way   <= w_gnt_idx;
                  r_ptr   <= w_ptr_nxt;
                  r_cmd0  <= req_cmd0[8*w_gnt_idx +: 8];
                  r_cmd1  <= req_cmd1[8*w_gnt_idx +: 8];
                  r_has1  <= req_has_cmd1[w_gnt_idx];
                  r_addr  <= req_addr[AW*w_gnt_idx +: AW];
                  r_cen   <= ~w_gnt_oh;
                  r_cle   <= 1'b1;
                  r_wrn   <= 1'b0;
                  r_dq    <= req_cmd0[8*w_gnt_idx +: 8];
                  r_dqoe  <= 1'b1;
                  r_state <= S_CMD0_L;
               end
            end
            S_CMD0_L: begin
               r_wrn   <= 1'b1;
               r_state <= S_CMD0_H;
            end
            S_CMD0_H: begin
               r_cle   <= 1'b0;
               r_ale   <= 1'b1;
               r_wrn   <= 1'b0;
               r_dq    <= r_addr[7:0];
               r_bcnt  <= '0;
               r_state <= S_ADDR_L;
            end
            S_ADDR_L: begin
               r_wrn   <= 1'b1;
               r_state <= S_ADDR_H;
            end
            S_ADDR_H: begin
               if (!w_last_addr) begin
                  r_addr  <= w_addr_shift;
                  r_dq    <= w_addr_shift[7:0];
                  r_bcnt  <= r_bcnt + 3'd1;
                  r_wrn   <= 1'b0;
                  r_state <= S_ADDR_L;
               end else if (r_has1) begin
                  r_ale   <= 1'b0;
                  r_cle   <= 1'b1;
                  r_wrn   <= 1'b0;
                  r_dq    <= r_cmd1;
                  r_state <= S_CMD1_L;
               end else begin
                  r_cen   <= '1;
                  r_ale   <= 1'b0;
                  r_cle   <= 1'b0;
                  r_dq    <= '0;
                  r_dqoe  <= 1'b0;
                  r_state <= S_REL;
               end
            end
            S_CMD1_L: begin
               r_wrn   <= 1'b1;
               r_state <= S_CMD1_H;
            end
            S_CMD1_H: begin
               r_cen   <= '1;
               r_cle   <= 1'b0;
               r_ale   <= 1'b0;
               r_dq    <= '0;
               r_dqoe  <= 1'b0;
               r_state <= S_REL;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Completion tracker: a release arm wins over everything, a done report clears.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_busy     <= '0;
         r_pend     <= '0;
         r_done_v   <= 1'b0;
         r_done_way <= '0;
         for (int w = 0; w < NWAY; w++) r_wb[w] <= '0;
      end else begin
         r_done_v <= w_done_any;
         if (w_done_any) r_done_way <= w_done_idx;
         for (int w = 0; w < NWAY; w++) begin
            if (w_to_rel && (r_way == WW'(w))) begin
               r_busy[w] <= 1'b1;
               r_pend[w] <= 1'b0;
               r_wb[w]   <= 4'(TWB);
            end else if (w_done_any && (w_done_idx == WW'(w))) begin
               r_busy[w] <= 1'b0;
               r_pend[w] <= 1'b0;
            end else if (r_busy[w]) begin
               if (r_wb[w] != 4'd0) r_wb[w] <= r_wb[w] - 4'd1;
               else if (r_rb_s[w]) r_pend[w] <= 1'b1;
            end
         end
      end
   end

   assign req_ready  = r_ready;
   assign done_valid = r_done_v;
   assign done_way   = r_done_way;
   assign CEN        = r_cen;
   assign CLE        = r_cle;
   assign ALE        = r_ale;
   assign WRN        = r_wrn;
   assign WPN        = r_wpn;
   assign DQ_O       = r_dq;
   assign DQ_OE      = r_dqoe;

endmodule
